// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared types and constants for the FFT frame scheduler.
//   sched_state_e : read-side FSM states
//   NSAMPLES_DEF  : default samples per frame
//   SAMPLE_W_DEF  : default sample width
//   FRAME_CNT_W   : width of the delivered-frame counter
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    STREAM   = 2'd2,
    WAIT_RES = 2'd3
  } sched_state_e;

  localparam int NSAMPLES_DEF = 1024;
  localparam int SAMPLE_W_DEF = 16;
  localparam int FRAME_CNT_W  = 16;

endpackage

// File: rtl/frame_bank_ram.sv
// frame_bank_ram: simple dual-port RAM holding both ping-pong banks,
// 2*NSAMPLES x W, address = {bank, idx}.
//   clk, reset     : clock; async active-high reset (clears read register only)
//   we/waddr/wdata : synchronous write port
//   re/raddr/rdata : registered synchronous read; rdata holds while re=0
module frame_bank_ram #(
  parameter int NSAMPLES = 1024,
  parameter int W        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [$clog2(NSAMPLES):0]   waddr,
  input  logic [W-1:0]                wdata,
  input  logic                        re,
  input  logic [$clog2(NSAMPLES):0]   raddr,
  output logic [W-1:0]                rdata
);

  logic [W-1:0] mem [0:2*NSAMPLES-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the output holding register: it only
  // advances when the scheduler asks for the next sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: collects audio samples into two ping-pong frame banks
// and streams each full frame to the FFT sink as a sop/eop packet. With
// WAIT_RESULT=1 the next frame is held off until result_valid is seen.
//   clk, reset                 : clock, async active-high reset
//   in_data/in_valid/in_ready  : sample input stream
//   fft_data/fft_valid/fft_ready/fft_sop/fft_eop : frame output stream
//   result_valid               : downstream pulse, current frame done
//   busy                       : read FSM not idle
//   frame_count                : eop handshakes, modulo 2^16
//   overflow                   : sticky, sample offered while in_ready=0
// Optional: define FFT_SCHED_TIMEOUT_EN to add a 16-bit WAIT_RES timeout
// and the sticky 'timeout' output.
module fft_frame_scheduler
  import fft_ctrl_pkg::*;
#(
  parameter int NSAMPLES    = NSAMPLES_DEF,
  parameter int W           = SAMPLE_W_DEF,
  parameter int WAIT_RESULT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [W-1:0]           in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [W-1:0]           fft_data,
  output logic                   fft_valid,
  input  logic                   fft_ready,
  output logic                   fft_sop,
  output logic                   fft_eop,
  input  logic                   result_valid,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   overflow
`ifdef FFT_SCHED_TIMEOUT_EN
  ,
  output logic                   timeout
`endif
);

  localparam int IW = $clog2(NSAMPLES);
  localparam logic [IW-1:0] LAST = IW'(NSAMPLES - 1);

  sched_state_e state, state_nxt;

  logic [1:0]    full, set_full, clr_full;
  logic          wr_bank, rd_bank;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          wr_acc, hs, eop_hs;
  logic          rd_en;
  logic [IW:0]   rd_addr;

  // ---------------- write side ----------------
  assign in_ready = !reset && !full[wr_bank];
  assign wr_acc   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank  <= 1'b0;
      wr_idx   <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (wr_acc) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_idx == LAST) wr_bank <= ~wr_bank;
      end
    end
  end

  // Fill and release always target different banks, so the two
  // per-bank updates never collide.
  always_comb begin
    set_full          = '0;
    clr_full          = '0;
    set_full[wr_bank] = wr_acc && (wr_idx == LAST);
    clr_full[rd_bank] = eop_hs;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) full <= '0;
    else       full <= (full | set_full) & ~clr_full;
  end

  // ---------------- read side ----------------
  assign fft_valid = (state == STREAM);
  assign busy      = (state != IDLE);
  assign hs        = fft_valid && fft_ready;
  assign eop_hs    = hs && fft_eop;

`ifdef FFT_SCHED_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_hit;
  assign to_hit = (state == WAIT_RES) && (to_cnt == 16'hFFFF) && !result_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_RES) ? to_cnt + 1'b1 : 16'd0;
      if (to_hit) timeout <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = {rd_bank, rd_idx};
    case (state)
      IDLE: if (full[rd_bank]) state_nxt = LOAD;
      LOAD: begin
        rd_en     = 1'b1;
        rd_addr   = {rd_bank, {IW{1'b0}}};
        state_nxt = STREAM;
      end
      STREAM: if (hs) begin
        if (fft_eop) begin
          if (WAIT_RESULT != 0)      state_nxt = WAIT_RES;
          else if (full[~rd_bank])   state_nxt = LOAD;
          else                       state_nxt = IDLE;
        end else begin
          // prefetch next sample so a held-high ready sees one beat per cycle
          rd_en   = 1'b1;
          rd_addr = {rd_bank, rd_idx + 1'b1};
        end
      end
      WAIT_RES: begin
        if (result_valid) state_nxt = IDLE;
`ifdef FFT_SCHED_TIMEOUT_EN
        else if (to_hit)  state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rd_bank     <= 1'b0;
      rd_idx      <= '0;
      fft_sop     <= 1'b0;
      fft_eop     <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        rd_idx  <= '0;
        fft_sop <= 1'b1;
        fft_eop <= 1'b0;
      end else if (hs) begin
        fft_sop <= 1'b0;
        if (fft_eop) begin
          fft_eop     <= 1'b0;
          rd_bank     <= ~rd_bank;
          frame_count <= frame_count + 1'b1;
        end else begin
          rd_idx  <= rd_idx + 1'b1;
          fft_eop <= (rd_idx == LAST - 1'b1);
        end
      end
    end
  end

  frame_bank_ram #(.NSAMPLES(NSAMPLES), .W(W)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr ({wr_bank, wr_idx}),
    .wdata (in_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (fft_data)
  );

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler (NSAMPLES=8). Two instances: 'dut' waits for
// result_valid, 'dut_fr' free-runs. A reference model tracks, at frame level,
// the queue of accepted samples, how many banks hold complete frames, the
// position inside the outgoing frame, sticky overflow and the frame count.
module tb_fft_frame_scheduler;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [15:0] in_data = '0;
  logic in_valid = 1'b0, fft_ready = 1'b0, result_valid = 1'b0;
  logic in_ready, fft_valid, fft_sop, fft_eop, busy, overflow;
  logic [15:0] fft_data, frame_count;

  logic [15:0] fr_in_data = '0;
  logic fr_in_valid = 1'b0, fr_fft_ready = 1'b0, fr_result_valid = 1'b0;
  logic fr_in_ready, fr_fft_valid, fr_fft_sop, fr_fft_eop, fr_busy, fr_overflow;
  logic [15:0] fr_fft_data, fr_frame_count;
`ifdef FFT_SCHED_TIMEOUT_EN
  logic timeout, fr_timeout;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fft_frame_scheduler #(.NSAMPLES(N), .W(16), .WAIT_RESULT(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fft_data(fft_data), .fft_valid(fft_valid), .fft_ready(fft_ready), .fft_sop(fft_sop),
    .fft_eop(fft_eop), .result_valid(result_valid), .busy(busy), .frame_count(frame_count),
    .overflow(overflow)
`ifdef FFT_SCHED_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  fft_frame_scheduler #(.NSAMPLES(N), .W(16), .WAIT_RESULT(0)) dut_fr (
    .clk(clk), .reset(reset), .in_data(fr_in_data), .in_valid(fr_in_valid), .in_ready(fr_in_ready),
    .fft_data(fr_fft_data), .fft_valid(fr_fft_valid), .fft_ready(fr_fft_ready), .fft_sop(fr_fft_sop),
    .fft_eop(fr_fft_eop), .result_valid(fr_result_valid), .busy(fr_busy), .frame_count(fr_frame_count),
    .overflow(fr_overflow)
`ifdef FFT_SCHED_TIMEOUT_EN
    , .timeout(fr_timeout)
`endif
  );

  // ---------------- reference model (main instance) ----------------
  logic [15:0] m_q[$];
  int m_fill, m_held, m_beat;
  logic [15:0] m_fc;
  logic m_ovf;
  wire m_ready = (m_held < 2);
  wire hs = fft_valid && fft_ready;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_fill <= 0; m_held <= 0; m_beat <= 0; m_fc <= '0; m_ovf <= 1'b0;
    end else begin
      if (hs) begin
        void'(m_q.pop_front());
        m_beat <= (m_beat == N-1) ? 0 : m_beat + 1;
        if (m_beat == N-1) m_fc <= m_fc + 16'd1;
      end
      if (in_valid && m_ready) begin
        m_q.push_back(in_data);
        m_fill <= (m_fill == N-1) ? 0 : m_fill + 1;
      end
      if (in_valid && !m_ready) m_ovf <= 1'b1;
      m_held <= m_held + ((in_valid && m_ready && m_fill == N-1) ? 1 : 0)
                       - ((hs && m_beat == N-1) ? 1 : 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_result();
    result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
    checks++; if ({fft_valid, fft_sop, fft_eop, busy, overflow} !== 5'b0) begin errors++;
      $display("FAIL rst_flags: got %b exp 00000", {fft_valid, fft_sop, fft_eop, busy, overflow}); end
    checks++; if (frame_count !== 16'd0 || fft_data !== 16'd0) begin errors++;
      $display("FAIL rst_counts: frame_count=%0h fft_data=%0h exp 0", frame_count, fft_data); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    int n, lat;
    fft_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = 16'(i + 1);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sf_in_ready: got %b exp 1", in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0; lat = -1;
    for (int c = 0; c < 20 && n < N; c++) begin
      @(negedge clk);
      if (fft_valid && lat < 0) lat = c;
      if (lat >= 0) begin
        checks++; if (fft_valid !== 1'b1) begin errors++; $display("FAIL sf_bubble: beat %0d valid=%b exp 1", n, fft_valid); end
      end
      if (fft_valid && fft_ready) begin
        checks++;
        if (fft_data !== 16'(n + 1) || m_q.size() == 0 || fft_data !== m_q[0] ||
            fft_sop !== (n == 0) || fft_eop !== (n == N-1)) begin
          errors++; $display("FAIL sf_beat%0d: data=%0h sop=%b eop=%b exp data=%0h", n, fft_data, fft_sop, fft_eop, n + 1);
        end
        n++;
      end
      @(posedge clk); #1;
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL sf_latency: got %0d exp 2", lat); end
    checks++; if (n !== N) begin errors++; $display("FAIL sf_beats: got %0d exp %0d", n, N); end
    @(negedge clk);
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL sf_frame_count: got %0d exp 1", frame_count); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || fft_valid !== 1'b0) begin errors++;
      $display("FAIL sf_wait: busy=%b valid=%b exp 1 0", busy, fft_valid); end
    @(posedge clk); #1;
    pulse_result();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sf_busy_release: got %b exp 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n;
    bit started, pstall, psop, peop;
    logic [15:0] pdata;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    fft_ready = 1'b0;
    n = 0; started = 0; pstall = 0; psop = 0; peop = 0; pdata = '0;
    for (int c = 0; c < 80 && n < N; c++) begin
      @(negedge clk);
      if (fft_valid) started = 1;
      if (pstall) begin
        checks++;
        if ({fft_valid, fft_data, fft_sop, fft_eop} !== {1'b1, pdata, psop, peop}) begin
          errors++; $display("FAIL bp_hold: data=%0h sop=%b eop=%b exp %0h %b %b", fft_data, fft_sop, fft_eop, pdata, psop, peop);
        end
      end
      if (started) begin
        checks++; if (fft_valid !== 1'b1) begin errors++; $display("FAIL bp_bubble: beat %0d valid=%b exp 1", n, fft_valid); end
      end
      if (fft_valid && fft_ready) begin
        checks++;
        if (m_q.size() == 0 || fft_data !== m_q[0] || fft_sop !== (n == 0) || fft_eop !== (n == N-1)) begin
          errors++; $display("FAIL bp_beat%0d: data=%0h sop=%b eop=%b exp data=%0h", n, fft_data, fft_sop, fft_eop,
                             (m_q.size() != 0) ? m_q[0] : 16'hxxxx);
        end
        n++;
      end
      pstall = fft_valid && !fft_ready;
      pdata = fft_data; psop = fft_sop; peop = fft_eop;
      @(posedge clk); #1;
      fft_ready = ~fft_ready;
    end
    fft_ready = 1'b1;
    checks++; if (n !== N) begin errors++; $display("FAIL bp_handshakes: got %0d exp %0d", n, N); end
    @(negedge clk);
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL bp_frame_count: got %0d exp 2", frame_count); end
    @(posedge clk); #1;
    pulse_result();
  endtask

  task automatic test_pingpong();
    int n;
    fft_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom);
      @(negedge clk);
      checks++; if (in_ready !== m_ready) begin errors++; $display("FAIL pp_in_ready%0d: got %b exp %b", i, in_ready, m_ready); end
      if (i == 16) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pp_drop17: got %b exp 0", in_ready); end
      end
      if (hs) begin
        checks++; if (m_q.size() == 0 || fft_data !== m_q[0] || fft_sop !== (n == 0)) begin
          errors++; $display("FAIL pp_f1_beat%0d: data=%0h sop=%b", n, fft_data, fft_sop); end
        n++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hs) begin
        checks++; if (m_q.size() == 0 || fft_data !== m_q[0] || fft_eop !== (n == N-1)) begin
          errors++; $display("FAIL pp_f1_beat%0d: data=%0h eop=%b", n, fft_data, fft_eop); end
        n++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (n !== N) begin errors++; $display("FAIL pp_held_off: beats=%0d exp %0d", n, N); end
    checks++; if (overflow !== 1'b1 || m_ovf !== 1'b1) begin errors++; $display("FAIL pp_overflow: got %b exp 1", overflow); end
    checks++; if (fft_valid !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL pp_waiting: valid=%b busy=%b exp 0 1", fft_valid, busy); end
    checks++; if (frame_count !== m_fc) begin errors++; $display("FAIL pp_fc1: got %0d exp %0d", frame_count, m_fc); end
    @(posedge clk); #1;
    pulse_result();
    n = 0;
    for (int c = 0; c < 30 && n < N; c++) begin
      @(negedge clk);
      if (hs) begin
        checks++; if (m_q.size() == 0 || fft_data !== m_q[0] || fft_sop !== (n == 0) || fft_eop !== (n == N-1)) begin
          errors++; $display("FAIL pp_f2_beat%0d: data=%0h sop=%b eop=%b", n, fft_data, fft_sop, fft_eop); end
        n++;
      end
      @(posedge clk); #1;
    end
    checks++; if (n !== N) begin errors++; $display("FAIL pp_f2_beats: got %0d exp %0d", n, N); end
    @(negedge clk);
    checks++; if (frame_count !== m_fc) begin errors++; $display("FAIL pp_fc2: got %0d exp %0d", frame_count, m_fc); end
    @(posedge clk); #1;
    pulse_result();
  endtask

  task automatic test_reset_mid();
    int n;
    logic [15:0] first;
    fft_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      in_valid = (c < N); in_data = 16'($urandom);
      @(negedge clk);
      if (hs) begin
        checks++; if (m_q.size() == 0 || fft_data !== m_q[0]) begin
          errors++; $display("FAIL rm_pre_beat%0d: data=%0h", n, fft_data); end
        n++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL rm_pre_beats: got %0d exp 3", n); end
    reset = 1'b1;
    #1;
    checks++; if (fft_valid !== 1'b0 || busy !== 1'b0 || fft_eop !== 1'b0) begin errors++;
      $display("FAIL rm_async: valid=%b busy=%b eop=%b exp 000", fft_valid, busy, fft_eop); end
    checks++; if (frame_count !== 16'd0 || overflow !== 1'b0) begin errors++;
      $display("FAIL rm_clear: frame_count=%0d overflow=%b exp 0 0", frame_count, overflow); end
    @(posedge clk); #1;
    reset = 1'b0;
    first = 16'($urandom);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = (i == 0) ? first : 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < N; c++) begin
      @(negedge clk);
      if (hs) begin
        checks++;
        if (m_q.size() == 0 || fft_data !== m_q[0] || fft_sop !== (n == 0) || fft_eop !== (n == N-1) ||
            (n == 0 && fft_data !== first)) begin
          errors++; $display("FAIL rm_beat%0d: data=%0h sop=%b eop=%b", n, fft_data, fft_sop, fft_eop);
        end
        n++;
      end
      @(posedge clk); #1;
    end
    checks++; if (n !== N || frame_count !== 16'd1) begin errors++;
      $display("FAIL rm_clean_frame: beats=%0d fc=%0d exp %0d 1", n, frame_count, N); end
    pulse_result();
  endtask

  task automatic test_freerun();
    logic [15:0] sent[$];
    logic [15:0] got[$];
    fr_fft_ready = 1'b1;
    for (int c = 0; c < 300 && got.size() < 32; c++) begin
      fr_in_valid = (sent.size() < 32) && fr_in_ready;
      fr_in_data = 16'($urandom);
      if (fr_in_valid) sent.push_back(fr_in_data);
      @(negedge clk);
      if (fr_fft_valid && fr_fft_ready) begin
        checks++;
        if (fr_fft_sop !== (got.size() % N == 0) || fr_fft_eop !== (got.size() % N == N-1)) begin
          errors++; $display("FAIL fr_framing%0d: sop=%b eop=%b", got.size(), fr_fft_sop, fr_fft_eop);
        end
        got.push_back(fr_fft_data);
      end
      @(posedge clk); #1;
    end
    fr_in_valid = 1'b0;
    checks++; if (got.size() !== 32) begin errors++; $display("FAIL fr_beats: got %0d exp 32", got.size()); end
    for (int i = 0; i < 32 && i < got.size(); i++) begin
      checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL fr_data%0d: got %0h exp %0h", i, got[i], sent[i]); end
    end
    @(negedge clk);
    checks++; if (fr_frame_count !== 16'd4) begin errors++; $display("FAIL fr_frame_count: got %0d exp 4", fr_frame_count); end
    checks++; if (fr_overflow !== 1'b0) begin errors++; $display("FAIL fr_overflow: got %b exp 0", fr_overflow); end
    @(posedge clk); #1;
  endtask

`ifdef FFT_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n, waited;
    bit seen;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    fft_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < N; c++) begin
      in_valid = (c < 2*N); in_data = 16'($urandom);
      @(negedge clk);
      if (hs) n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL to_pre: timeout=%b busy=%b exp 0 1", timeout, busy); end
    waited = 0; seen = 0;
    for (int c = 0; c < 70000 && !seen; c++) begin
      @(negedge clk);
      if (timeout) seen = 1; else waited++;
      if (!seen && fft_valid) begin
        checks++; errors++; $display("FAIL to_early_frame: valid=%b exp 0 at wait %0d", fft_valid, waited);
      end
      @(posedge clk); #1;
    end
    checks++; if (!seen || waited < 65535) begin errors++;
      $display("FAIL to_timeout: seen=%b waited=%0d exp 1 >=65535", seen, waited); end
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (fft_valid) begin
        seen = 1;
        checks++; if (fft_sop !== 1'b1 || m_q.size() == 0 || fft_data !== m_q[0]) begin errors++;
          $display("FAIL to_next_frame: sop=%b data=%0h", fft_sop, fft_data); end
      end
      @(posedge clk); #1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_proceed: valid=0 exp 1"); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_pingpong();
    test_reset_mid();
    test_freerun();
`ifdef FFT_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Sits between the filtered audio stream and the FFT/pitch-detect datapath.
- Collects samples into ping-pong frame banks of NSAMPLES each.
- Streams each full frame to the FFT sink as one packet (sop/eop).
- Holds off the next frame until the pitch stage reports that the current frame is done; reports overflow and frame count.

Parameters:
NSAMPLES, 1024, samples per frame; power of two, >=4
W, 16, sample width
WAIT_RESULT, 1, 1 = block the next frame until result_valid is seen; 0 = free-run

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
in_data  in  W  filtered audio sample
in_valid  in  1  sample valid
in_ready  out  1  scheduler can accept sample
fft_data  out  W  frame sample to FFT
fft_valid  out  1  fft_data valid
fft_ready  in  1  FFT sink ready
fft_sop  out  1  first sample of frame
fft_eop  out  1  last sample of frame
result_valid  in  1  pitch result pulse from downstream; marks frame done
busy  out  1  FSM not in IDLE
frame_count  out  16  frames fully delivered (eop handshakes); wraps at 65535->0
overflow  out  1  sticky: sample offered while in_ready=0

Behaviour:
- Reset (async, immediate): all outputs 0, except in_ready=1 from the first cycle after reset deasserts. Both bank-full flags are cleared and in-flight frames are discarded. A reset mid-frame produces no eop.
- Write side:
  - wr_bank/wr_idx write a sample on in_valid&&in_ready.
  - The accept with wr_idx==NSAMPLES-1 sets full[wr_bank], toggles wr_bank and sets wr_idx=0.
  - in_ready = !full[wr_bank].
- Overflow: set on any cycle with in_valid && !in_ready. Cleared only by reset. The sample is dropped.
- Read FSM, states IDLE, LOAD, STREAM, WAIT_RES:
  - IDLE: if full[rd_bank], go to LOAD. LOAD issues a RAM read of address 0.
  - LOAD -> STREAM. fft_valid rises 2 cycles after the full flag is set.
  - STREAM: fft_valid=1. fft_data, sop and eop are registered and held stable while fft_ready=0.
  - On each handshake, the next address is read so the output keeps one sample per cycle while fft_ready stays high.
  - fft_sop=1 for index 0 only. fft_eop=1 for index NSAMPLES-1 only.
  - On the eop handshake: clear full[rd_bank], toggle rd_bank, increment frame_count. Next state is WAIT_RES if WAIT_RESULT=1, else IDLE (or LOAD directly if the other bank is already full).
  - WAIT_RES: on result_valid=1, go to IDLE. A result_valid arriving in any other state is ignored.
- Simultaneous events:
  - A bank fill and the other bank's release in the same cycle update independently.
  - If the write side is stalled on the bank being released, in_ready rises the following cycle.
- fft_valid never drops mid-frame once STREAM is entered (no bubbles inserted by the scheduler).
- Arithmetic:
  - wr_idx and rd_idx are $clog2(NSAMPLES) bits and wrap naturally.
  - frame_count is modulo 2^16.

Optional Feature:
- Macro: FFT_SCHED_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in WAIT_RES.
  - If it reaches 16'hFFFF without result_valid, the FSM returns to IDLE.
  - A sticky timeout output port (1 bit, reset 0) is set.
- When undefined: there is no counter and no timeout port, and WAIT_RES waits indefinitely.

Decomposition:
- Package fft_ctrl_pkg holds:
  - the sched_state_e enum {IDLE, LOAD, STREAM, WAIT_RES}
  - default constants NSAMPLES_DEF=1024 and SAMPLE_W_DEF=16
  - the FRAME_CNT_W=16 constant
- One sub-module, frame_bank_ram: simple dual-port RAM of 2*NSAMPLES x W with sync write and registered sync read. Address = {bank, idx}.

Test Plan (NSAMPLES=8, W=16 unless stated):
- Single frame:
  - Stimulus: feed 0x0001..0x0008 with fft_ready=1.
  - Required: fft_valid 2 cycles after the 8th accept; 8 consecutive beats; sop on 0x0001; eop on 0x0008; frame_count=1; busy high until result_valid.
- Backpressure:
  - Stimulus: toggle fft_ready 1/0 every cycle during STREAM.
  - Required: data sequence intact, outputs held while ready=0, exactly 8 handshakes.
- Ping-pong fill:
  - Stimulus: stream 24 samples continuously, withhold result_valid.
  - Required: in_ready drops after sample 16; sample 17 onward sets overflow=1; frame 2 is not emitted until result_valid is pulsed.
- Free-run:
  - Stimulus: WAIT_RESULT=0; 32 continuous samples.
  - Required: 4 frames with no overflow; frame_count=4.
- Reset mid-frame:
  - Stimulus: assert reset after the 3rd output beat.
  - Required: fft_valid=0 immediately; frame_count=0; overflow=0; the next 8 inputs produce a clean frame starting with sop.
- With FFT_SCHED_TIMEOUT_EN:
  - Stimulus: no result_valid after frame 1.
  - Required: timeout=1 after 65535 cycles in WAIT_RES; the FSM proceeds to the next frame.
